// File: rtl/mult_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mult_arbiter_if : requester and coprocessor signals of mult_arbiter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mult_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   ack;
  logic [15:0]       rsp_prod;
  logic [3:0]        rsp_cc;
  logic              rsp_err;
  logic              busy;
  logic              mult_start;
  logic [7:0]        mult_a;
  logic [7:0]        mult_b;
  logic [15:0]       mult_out;
  logic              mult_done;
  logic [3:0]        mult_cc;

  // Arbiter side
  modport slave (
    input  req, req_a, req_b, mult_out, mult_done, mult_cc,
    output ack, rsp_prod, rsp_cc, rsp_err, busy, mult_start, mult_a, mult_b
  );

  // Requester/coprocessor side
  modport master (
    output req, req_a, req_b, mult_out, mult_done, mult_cc,
    input  ack, rsp_prod, rsp_cc, rsp_err, busy, mult_start, mult_a, mult_b
  );
endinterface

`default_nettype wire

// File: rtl/mult_arbiter.sv
// +----------------------------------------------------------------------+
// | mult_arbiter : round-robin sharing of one 8x8 multiply coprocessor   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clock,
  input  logic            reset,
  mult_arbiter_if.slave   bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     prod_q, prod_d;
  logic [3:0]      cc_q, cc_d;
  logic            err_q, err_d;

  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [IW:0]     sum;

  // Scan offsets from highest to lowest so the nearest set bit at or after
  // the pointer is the one left standing.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sum      = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) begin
        sum = sum - (IW+1)'(NREQ);
      end
      if (bus.req[sum[IW-1:0]]) begin
        pick     = sum[IW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      cc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      cc_q    <= cc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    cc_d    = cc_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          a_d     = bus.req_a[{pick, 3'b000} +: 8];
          b_d     = bus.req_b[{pick, 3'b000} +: 8];
          state_d = S_START;
        end
      end
      // done may still be high from the previous operation, so it is not looked at here
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mult_done) begin
          prod_d  = bus.mult_out;
          cc_d    = bus.mult_cc;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          prod_d  = '0;
          cc_d    = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == S_RESP) begin
      bus.ack[gnt_q] = 1'b1;
    end
  end

  assign bus.mult_start = (state_q == S_START);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.mult_a     = a_q;
  assign bus.mult_b     = b_q;
  assign bus.rsp_prod   = prod_q;
  assign bus.rsp_cc     = cc_q;
  assign bus.rsp_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mult_arbiter : directed self-checking bench for mult_arbiter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mult_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic clock = 1'b0;
  logic reset;

  mult_arbiter_if #(.NREQ(NREQ)) bus ();

  mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Coprocessor model: done drops on start and rises in the 9th cycle after it
  logic        stub   = 1'b0;
  logic        done_r = 1'b1;
  int          mcnt   = 0;
  logic [15:0] mprod  = '0;
  logic [15:0] mout   = '0;

  always @(posedge clock) begin
    if (bus.mult_start) begin
      mcnt   <= 8;
      done_r <= 1'b0;
      mprod  <= {{8{bus.mult_a[7]}}, bus.mult_a} * {{8{bus.mult_b[7]}}, bus.mult_b};
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt   <= 0;
      done_r <= 1'b1;
      mout   <= mprod;
    end
  end

  assign bus.mult_out  = mout;
  assign bus.mult_cc   = {(mout == 16'h0000), 1'b0, mout[15], 1'b0};
  assign bus.mult_done = done_r & ~stub;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " ack"},        32'(bus.ack),        32'h0);
    check({tag, " rsp_prod"},   32'(bus.rsp_prod),   32'h0);
    check({tag, " rsp_cc"},     32'(bus.rsp_cc),     32'h0);
    check({tag, " rsp_err"},    32'(bus.rsp_err),    32'h0);
    check({tag, " mult_start"}, 32'(bus.mult_start), 32'h0);
    check({tag, " mult_a"},     32'(bus.mult_a),     32'h0);
    check({tag, " mult_b"},     32'(bus.mult_b),     32'h0);
    check({tag, " busy"},       32'(bus.busy),       32'h0);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*8 +: 8] = a;
    bus.req_b[i*8 +: 8] = b;
    bus.req[i]          = 1'b1;
  endtask

  // Waits (bounded) for an ack, counting cycles, start pulses and non-busy cycles.
  task automatic wait_ack(input int scr, output logic [3:0] a, output int cyc,
                          output int starts, output logic busy_ok);
    a = '0; cyc = 0; starts = 0; busy_ok = 1'b1;
    while (a == '0 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      a = bus.ack;
      if (bus.mult_start) starts++;
      if (!bus.busy) busy_ok = 1'b0;
      if (cyc == 3 && scr >= 0) begin
        bus.req_a[scr*8 +: 8] = ~bus.req_a[scr*8 +: 8];
        bus.req_b[scr*8 +: 8] = ~bus.req_b[scr*8 +: 8];
      end
    end
  endtask

  task automatic do_single(input string tag, input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] prod, input logic [3:0] cc, input logic err,
                           input int lat);
    logic [3:0] ak; int cyc; int starts; logic bok;
    set_op(i, a, b);
    wait_ack(i, ak, cyc, starts, bok);
    check({tag, " ack"},      32'(ak),           32'(4'b0001 << i));
    check({tag, " latency"},  32'(cyc),          32'(lat));
    check({tag, " rsp_prod"}, 32'(bus.rsp_prod), 32'(prod));
    check({tag, " rsp_cc"},   32'(bus.rsp_cc),   32'(cc));
    check({tag, " rsp_err"},  32'(bus.rsp_err),  32'(err));
    check({tag, " starts"},   32'(starts),       32'd1);
    check({tag, " busy"},     32'(bok),          32'd1);
    check({tag, " mult_a"},   32'(bus.mult_a),   32'(a));
    check({tag, " mult_b"},   32'(bus.mult_b),   32'(b));
    bus.req[i] = 1'b0;
  endtask

  typedef struct {
    int          idx;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    logic [3:0]  cc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ak;
    int cyc, starts;
    logic bok;
    logic [15:0] rr_prod[4];
    int          fair_idx[4];
    logic [15:0] fair_prod[4];

    vecs[0] = '{0, 8'hFF, 8'hFF, 16'h0001, 4'b0000};
    vecs[1] = '{1, 8'h03, 8'hFB, 16'hFFF1, 4'b0010};
    vecs[2] = '{1, 8'h00, 8'h55, 16'h0000, 4'b1000};
    vecs[3] = '{2, 8'h7F, 8'h7F, 16'h3F01, 4'b0000};
    vecs[4] = '{3, 8'h80, 8'h80, 16'h4000, 4'b0000};
    vecs[5] = '{3, 8'h80, 8'h7F, 16'hC080, 4'b0010};
    vecs[6] = '{2, 8'h01, 8'h80, 16'hFF80, 4'b0010};

    rr_prod   = '{16'h0006, 16'hFFFA, 16'h0100, 16'h0000};
    fair_idx  = '{0, 2, 0, 2};
    fair_prod = '{16'hFFFE, 16'h0019, 16'hFFFE, 16'h0019};

    reset     = 1'b1;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 7; v++) begin
      do_single($sformatf("vec%0d", v), vecs[v].idx, vecs[v].a, vecs[v].b,
                vecs[v].prod, vecs[v].cc, 1'b0, 11);
      @(negedge clock);
    end

    // Round robin from pointer 0 with all four requesting at once
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    set_op(0, 8'h02, 8'h03);
    set_op(1, 8'hFE, 8'h03);
    set_op(2, 8'h10, 8'h10);
    set_op(3, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      wait_ack(-1, ak, cyc, starts, bok);
      check($sformatf("rr%0d ack", k),     32'(ak),           32'(4'b0001 << k));
      check($sformatf("rr%0d spacing", k), 32'(cyc),          (k == 0) ? 32'd11 : 32'd12);
      check($sformatf("rr%0d rsp_prod", k), 32'(bus.rsp_prod), 32'(rr_prod[k]));
      bus.req = bus.req & ~ak;
    end
    @(negedge clock);

    // Fairness: req[0] re-raised after each of its acks, req[2] held
    reset = 1'b1; @(negedge clock); reset = 1'b0;
    set_op(0, 8'hFF, 8'h02);
    set_op(2, 8'h05, 8'h05);
    for (int k = 0; k < 4; k++) begin
      wait_ack(-1, ak, cyc, starts, bok);
      check($sformatf("fair%0d ack", k),      32'(ak),           32'(4'b0001 << fair_idx[k]));
      check($sformatf("fair%0d rsp_prod", k), 32'(bus.rsp_prod), 32'(fair_prod[k]));
      if (k < 3 && ak[0]) begin
        bus.req[0] = 1'b0;
        @(negedge clock);
        bus.req[0] = 1'b1;
      end
    end
    bus.req = '0;
    @(negedge clock);

    // Timeout with done stuck low, then recovery
    stub = 1'b1;
    do_single("timeout", 1, 8'h04, 8'h04, 16'h0000, 4'b0000, 1'b1, TIMEOUT + 2);
    stub = 1'b0;
    @(negedge clock);
    do_single("recover", 2, 8'h03, 8'h03, 16'h0009, 4'b0000, 1'b0, 11);
    @(negedge clock);

    // Reset in the 4th WAIT cycle; pointer is 3 beforehand
    set_op(2, 8'h06, 8'h07);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle_outputs("midreset");
    set_op(3, 8'h02, 8'h09);
    wait_ack(-1, ak, cyc, starts, bok);
    check("midreset regrant ack",  32'(ak),           32'h4);
    check("midreset regrant lat",  32'(cyc),          32'd11);
    check("midreset regrant prod", 32'(bus.rsp_prod), 32'h002A);
    bus.req[2] = 1'b0;
    wait_ack(-1, ak, cyc, starts, bok);
    check("midreset next ack",  32'(ak),           32'h8);
    check("midreset next lat",  32'(cyc),          32'd12);
    check("midreset next prod", 32'(bus.rsp_prod), 32'h0012);
    bus.req[3] = 1'b0;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
